mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port arbiter that serialises single-word read/write requests from the CPU Wishbone path and the per-accelerator DMA engines onto one shared memory port with fixed read latency. Generalises the fixed four-port arbiter in the user project wrapper to a configurable port count, address/data width and memory latency. Replaces first-come selection with fair round-robin, plus an optional CPU strict-priority mode. Sits between the request sources (port 0 = CPU, ports 1..N-1 = DMAs) and the user-area memory macro.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (legal 2..8); port 0 is the CPU
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en (legal 1..7)

Ports (one clock; reset is asynchronous and active-low; clock `clk`, reset `rst_n`):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request, held high until that port's resp_valid
- req_rw  in  NUM_PORTS  per-port 1 = write, 0 = read
- req_addr  in  NUM_PORTS*ADDR_W  flattened, port p at [p*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*DATA_W  flattened write data
- resp_valid  out  NUM_PORTS  one-cycle completion pulse to the granted port
- resp_data  out  DATA_W  read data, valid with resp_valid (0 for writes)
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the mem_en cycle
- grant_id  out  3  index of the port currently/last granted
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the winner, register its rw/addr/wdata and grant_id, go to ISSUE; else stay.
- ISSUE: mem_en=1, mem_we=rw, mem_addr/mem_wdata from registers. Write → RESP. Read → WAIT with counter loaded to MEM_LAT.
- WAIT: decrement counter each cycle; at counter==1 capture mem_rdata into resp_data register and go to RESP.
- RESP: resp_valid[grant_id]=1 for exactly one cycle, update round-robin pointer to grant_id, go to IDLE.
- Round-robin: search starts at pointer+1 modulo NUM_PORTS; first requesting port wins. Pointer resets to NUM_PORTS-1 so port 0 wins the first tie.
- Requester contract: req fields stable while req_valid high; requester drops req_valid (or presents a new request) the cycle after resp_valid. A request re-sampled in IDLE is a new transaction.
- req_valid deasserted before resp_valid is a protocol violation; the arbiter completes the latched transaction regardless.
- resp_data holds its last read value until the next read capture; it is cleared to 0 on a write's RESP.
- Unused grant_id bits are 0.

## Timing
- Reset values: resp_valid=0, resp_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, grant_id=0, busy=0; FSM=IDLE, pointer=NUM_PORTS-1.
- Request sampled in cycle T (IDLE): mem_en in T+1; write resp_valid in T+2; read resp_valid in T+1+MEM_LAT+1 (T+3 for MEM_LAT=1).
- Back-to-back: next arbitration in the cycle after RESP; peak throughput one write per 3 cycles, one read per MEM_LAT+3 cycles.
- Simultaneous requests: resolved only in IDLE; requests arriving during ISSUE/WAIT/RESP wait.
- rst_n low mid-transaction: in-flight access abandoned, no resp_valid issued, all outputs to reset values asynchronously.

## Configuration
- ARB_CPU_PRIORITY_EN defined: port 0 wins in IDLE whenever req_valid[0] is high; ports 1..N-1 round-robin among themselves; the pointer is not updated by port-0 grants.
- Undefined: all NUM_PORTS ports share one round-robin pointer.

## Test plan
- Single read, MEM_LAT=1: port 2 reads addr 0x10 holding 0xDEADBEEF → mem_en at T+1 with mem_addr=0x10, resp_valid[2] and resp_data=0xDEADBEEF at T+3.
- Single write: port 1 writes 0x1234 to 0x20 → mem_en=mem_we=1 at T+1 with correct addr/data, resp_valid[1] at T+2, resp_data=0.
- Fairness, 4 ports all requesting continuously, no macro → grant order 0,1,2,3,0,1...; each port gets exactly 25 of 100 grants.
- ARB_CPU_PRIORITY_EN, all ports continuously requesting → port 0 granted every transaction; with port 0 idle, ports 1,2,3 rotate.
- MEM_LAT=4 read → resp_valid at T+6, data from the cycle 4 after mem_en; WAIT lasts 4 cycles.
- rst_n pulsed low during WAIT → no resp_valid, busy=0, next request after reset granted to port 0 on tie.

Source files
------------

// File: rtl/mem_arbiter_rr_if.sv
// Request/response and memory-side bus of the round-robin memory arbiter.
// slave  : the arbiter itself
// master : the requesters plus the memory macro, i.e. everything around the arbiter
interface mem_arbiter_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    // requester side, port p packed at [p*W +: W]
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_rw;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        resp_valid;
    logic [DATA_W-1:0]           resp_data;

    // shared memory port
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    // status
    logic [2:0]                  grant_id;
    logic                        busy;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, mem_rdata,
        output resp_valid, resp_data, mem_en, mem_we, mem_addr, mem_wdata,
        output grant_id, busy
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, mem_rdata,
        input  resp_valid, resp_data, mem_en, mem_we, mem_addr, mem_wdata,
        input  grant_id, busy
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter serialising single-word requests onto one
// fixed-latency memory port. Port 0 is the CPU, ports 1..N-1 are DMAs.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// Optional macro ARB_CPU_PRIORITY_EN: port 0 always wins when requesting and
// the remaining ports rotate among themselves; port-0 grants leave the
// round-robin pointer untouched.
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 4,   // 2..8
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1    // 1..7
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_rr_if.slave bus
);

`ifdef ARB_CPU_PRIORITY_EN
    localparam bit CPU_PRI = 1'b1;
`else
    localparam bit CPU_PRI = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [2:0]           lat_cnt;

    logic [NUM_PORTS-1:0] rr_mask;
    logic                 win_found;
    logic [2:0]           win_id;
    logic                 win_rw;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    // Winner selection: the requesting port closest after rr_ptr wins.
    // Distance is (j - ptr - 1) mod N, so ptr itself is served last.
    always_comb begin
        int d;
        int best_d;
        rr_mask   = bus.req_valid;
        if (CPU_PRI) rr_mask[0] = 1'b0;
        win_found = 1'b0;
        win_id    = '0;
        win_rw    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        best_d    = NUM_PORTS;
        d         = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            d = j - int'(rr_ptr) - 1;
            if (d < 0) d = d + NUM_PORTS;
            if (rr_mask[j] && d < best_d) begin
                best_d    = d;
                win_found = 1'b1;
                win_id    = 3'(j);
                win_rw    = bus.req_rw[j];
                win_addr  = bus.req_addr[j*ADDR_W +: ADDR_W];
                win_wdata = bus.req_wdata[j*DATA_W +: DATA_W];
            end
        end
        // CPU override in priority mode
        if (CPU_PRI && bus.req_valid[0]) begin
            win_found = 1'b1;
            win_id    = '0;
            win_rw    = bus.req_rw[0];
            win_addr  = bus.req_addr[0 +: ADDR_W];
            win_wdata = bus.req_wdata[0 +: DATA_W];
        end
    end

    // Transaction FSM; every bus output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= 3'(NUM_PORTS - 1);
            lat_cnt        <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.grant_id   <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.resp_valid <= '0;
            bus.mem_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= win_rw;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.grant_id  <= win_id;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mem_we still holds the latched rw of this transaction
                    if (bus.mem_we) begin
                        bus.resp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << bus.grant_id;
                        bus.resp_data  <= '0;
                        state          <= RESP;
                    end else begin
                        lat_cnt <= 3'(MEM_LAT);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        bus.resp_data  <= bus.mem_rdata;
                        bus.resp_valid <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << bus.grant_id;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (!(CPU_PRI && bus.grant_id == 3'd0)) rr_ptr <= bus.grant_id;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: one DUT with MEM_LAT=1, one with MEM_LAT=4,
// each with a memory model that presents read data only in the exact cycle.
module tb_mem_arbiter_rr;

`ifdef ARB_CPU_PRIORITY_EN
    localparam bit PRI = 1'b1;
`else
    localparam bit PRI = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32)) bus4 ();

    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h30:  return 32'hCAFEF00D;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // latency-1 memory: data valid only in the cycle right after mem_en
    logic        v0;
    logic [31:0] d0;
    always @(posedge clk) begin
        v0 <= bus0.mem_en && !bus0.mem_we;
        d0 <= mem_read(bus0.mem_addr);
    end
    assign bus0.mem_rdata = v0 ? d0 : 32'hBADBAD00;

    // latency-4 memory: data valid only in the 4th cycle after mem_en
    logic [3:0]  v4;
    logic [31:0] d4 [4];
    always @(posedge clk) begin
        v4    <= {v4[2:0], bus4.mem_en && !bus4.mem_we};
        d4[0] <= mem_read(bus4.mem_addr);
        for (int i = 1; i < 4; i++) d4[i] <= d4[i-1];
    end
    assign bus4.mem_rdata = v4[3] ? d4[3] : 32'hBAD4BAD4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.req_valid = '0;
        bus4.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int ep;
        int first;
        int second;
        int cnt [4];
        bit seen;

        checks   = 0;
        failures = 0;
        bus0.req_valid = '0; bus0.req_rw = '0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus4.req_valid = '0; bus4.req_rw = '0; bus4.req_addr = '0; bus4.req_wdata = '0;
        rst_n = 1'b0;

        // ---- reset values ----
        tick();
        tick();
        check("rst_resp_valid", bus0.resp_valid, 0);
        check("rst_resp_data",  bus0.resp_data,  0);
        check("rst_mem_en",     bus0.mem_en,     0);
        check("rst_mem_we",     bus0.mem_we,     0);
        check("rst_mem_addr",   bus0.mem_addr,   0);
        check("rst_mem_wdata",  bus0.mem_wdata,  0);
        check("rst_grant_id",   bus0.grant_id,   0);
        check("rst_busy",       bus0.busy,       0);
        rst_n = 1'b1;
        tick();

        // ---- single read, port 2, addr 0x10 ----
        bus0.req_addr[2*32 +: 32] = 32'h10;
        bus0.req_rw[2]    = 1'b0;
        bus0.req_valid[2] = 1'b1;
        tick(); // T+1
        check("rd_mem_en",   bus0.mem_en,   1);
        check("rd_mem_we",   bus0.mem_we,   0);
        check("rd_mem_addr", bus0.mem_addr, 32'h10);
        check("rd_grant_id", bus0.grant_id, 2);
        check("rd_busy",     bus0.busy,     1);
        tick(); // T+2
        check("rd_no_early_resp", bus0.resp_valid, 0);
        check("rd_en_one_cycle",  bus0.mem_en,     0);
        tick(); // T+3
        check("rd_resp_valid", bus0.resp_valid, 4'b0100);
        check("rd_resp_data",  bus0.resp_data,  32'hDEADBEEF);
        bus0.req_valid = '0;
        tick();
        check("rd_idle_busy",   bus0.busy,       0);
        check("rd_resp_pulse",  bus0.resp_valid, 0);
        check("rd_data_holds",  bus0.resp_data,  32'hDEADBEEF);

        // ---- single write, port 1, 0x1234 -> 0x20 ----
        bus0.req_addr[1*32 +: 32]  = 32'h20;
        bus0.req_wdata[1*32 +: 32] = 32'h1234;
        bus0.req_rw[1]    = 1'b1;
        bus0.req_valid[1] = 1'b1;
        tick(); // T+1
        check("wr_mem_en",    bus0.mem_en,    1);
        check("wr_mem_we",    bus0.mem_we,    1);
        check("wr_mem_addr",  bus0.mem_addr,  32'h20);
        check("wr_mem_wdata", bus0.mem_wdata, 32'h1234);
        check("wr_grant_id",  bus0.grant_id,  1);
        tick(); // T+2
        check("wr_resp_valid", bus0.resp_valid, 4'b0010);
        check("wr_resp_data",  bus0.resp_data,  0);
        bus0.req_valid = '0;
        tick();

        // ---- tie between ports 0 and 3 with pointer at 1 ----
        first  = PRI ? 0 : 3;
        second = PRI ? 3 : 0;
        bus0.req_rw = 4'b1111;
        bus0.req_addr[0*32 +: 32] = 32'h40; bus0.req_wdata[0*32 +: 32] = 32'hA0;
        bus0.req_addr[3*32 +: 32] = 32'h70; bus0.req_wdata[3*32 +: 32] = 32'hA3;
        bus0.req_valid = 4'b1001;
        tick();
        check("tie_first_grant", bus0.grant_id, first);
        check("tie_first_addr",  bus0.mem_addr, first == 0 ? 32'h40 : 32'h70);
        tick();
        check("tie_first_resp", bus0.resp_valid, 4'b0001 << first);
        bus0.req_valid[first] = 1'b0;
        tick();
        tick();
        check("tie_second_grant", bus0.grant_id, second);
        tick();
        check("tie_second_resp", bus0.resp_valid, 4'b0001 << second);
        bus0.req_valid = '0;
        tick();

        // ---- ports 1..3 rotate with port 0 idle ----
        do_reset();
        bus0.req_valid = 4'b1110;
        g = 0;
        for (int c = 0; c < 60 && g < 6; c++) begin
            tick();
            if (bus0.resp_valid != 0) begin
                ep = 1 + (g % 3);
                check("rot_order", bus0.resp_valid, 4'b0001 << ep);
                g++;
            end
        end
        check("rot_grant_count", g, 6);
        do_reset();

        // ---- fairness, all four ports requesting continuously ----
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        bus0.req_valid = 4'b1111;
        g = 0;
        for (int c = 0; c < 400 && g < 100; c++) begin
            tick();
            if (bus0.resp_valid != 0) begin
                ep = PRI ? 0 : g % 4;
                check("fair_order", bus0.resp_valid, 4'b0001 << ep);
                for (int p = 0; p < 4; p++) if (bus0.resp_valid[p]) cnt[p]++;
                g++;
            end
        end
        check("fair_grant_count", g, 100);
        for (int p = 0; p < 4; p++)
            check("fair_per_port", cnt[p], PRI ? (p == 0 ? 100 : 0) : 25);
        bus0.req_valid = '0;
        tick();
        tick();
        tick();

        // ---- MEM_LAT=4 read, port 1, addr 0x30 ----
        bus4.req_addr[1*32 +: 32] = 32'h30;
        bus4.req_rw[1]    = 1'b0;
        bus4.req_valid[1] = 1'b1;
        tick(); // T+1
        check("l4_mem_en",   bus4.mem_en,   1);
        check("l4_mem_addr", bus4.mem_addr, 32'h30);
        check("l4_grant_id", bus4.grant_id, 1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("l4_wait_no_resp", bus4.resp_valid, 0);
            check("l4_wait_busy",    bus4.busy,       1);
        end
        tick(); // T+6
        check("l4_resp_valid", bus4.resp_valid, 4'b0010);
        check("l4_resp_data",  bus4.resp_data,  32'hCAFEF00D);
        bus4.req_valid = '0;
        tick();

        // ---- reset pulsed during WAIT ----
        bus4.req_addr[3*32 +: 32] = 32'h50;
        bus4.req_rw[3]    = 1'b0;
        bus4.req_valid[3] = 1'b1;
        tick(); // ISSUE
        tick(); // WAIT
        tick(); // WAIT
        check("rw_busy_before", bus4.busy, 1);
        rst_n = 1'b0;
        #1;
        check("rw_async_busy",      bus4.busy,       0);
        check("rw_async_grant",     bus4.grant_id,   0);
        check("rw_async_mem_addr",  bus4.mem_addr,   0);
        check("rw_async_resp_data", bus4.resp_data,  0);
        bus4.req_valid = '0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus4.resp_valid != 0) seen = 1'b1;
        end
        check("rw_no_resp_after_reset", seen, 0);
        bus4.req_addr[0*32 +: 32] = 32'h10;
        bus4.req_addr[2*32 +: 32] = 32'h60;
        bus4.req_rw = 4'b0000;
        bus4.req_valid = 4'b0101;
        tick();
        check("rw_tie_grant_p0", bus4.grant_id, 0);
        check("rw_tie_mem_en",   bus4.mem_en,   1);
        check("rw_tie_addr",     bus4.mem_addr, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
